// File: rtl/btn_filter_pkg.sv
// btn_filter_pkg: shared FSM encodings and pulse-vector indices for the button qualifier.
package btn_filter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } ch_state_e;
  localparam int unsigned PI_PRESS   = 0;
  localparam int unsigned PI_CLICK   = 1;
  localparam int unsigned PI_LONG    = 2;
  localparam int unsigned PI_RELEASE = 3;
  localparam int unsigned NUM_PULSE  = 4;
endpackage

// File: rtl/btn_filter_ch.sv
// btn_filter_ch: one button channel - synchroniser, leaky integrator with hysteresis,
// hold timer and press/click/long/release classifier with registered pulses.
module btn_filter_ch
  import btn_filter_pkg::*;
#(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned PRESS_TH   = 4096,
  parameter int unsigned RELEASE_TH = 2048,
  parameter int unsigned DEC_STEP   = 115,
  parameter int unsigned HOLD_W     = 17,
  parameter int unsigned LONG_TH    = 65536,
  parameter logic        ACT_LOW    = 1'b1
) (
  input  logic                 i_clk_32k,
  input  logic                 i_rst_n,
  input  logic                 i_btn,
  input  logic                 i_en,
  output logic                 o_pressed,
  output logic                 o_long,
  output logic [NUM_PULSE-1:0] o_pulse
);
  localparam logic [CNT_W-1:0]  PRESS_V = CNT_W'(PRESS_TH);
  localparam logic [CNT_W-1:0]  REL_V   = CNT_W'(RELEASE_TH);
  localparam logic [HOLD_W-1:0] LONG_V  = HOLD_W'(LONG_TH);
  localparam logic [31:0]       DEC_V   = 32'(DEC_STEP);
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_PULSE-1:0] pulse_q, pulse_d;
  logic [31:0]          cnt_ext;
  ch_state_e            state_q, state_d;
  // Polarity is applied before the synchroniser so a reset value of 0 means released.
  always_comb begin
    sync_d  = {sync_q[0], i_btn ^ ACT_LOW};
    cnt_ext = 32'(cnt_q);
    cnt_d   = sync_q[1] ? (&cnt_q ? cnt_q : cnt_q + CNT_W'(1))
                        : (cnt_ext >= DEC_V ? CNT_W'(cnt_ext - DEC_V) : '0);
    hold_d  = '0;
    state_d = state_q;
    pulse_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_d >= PRESS_V) begin
          state_d           = ST_PRESSED;
          pulse_d[PI_PRESS] = 1'b1;
        end
      end
      ST_PRESSED: begin
        hold_d = &hold_q ? hold_q : hold_q + HOLD_W'(1);
        if (cnt_d < REL_V) begin
          state_d             = ST_IDLE;
          hold_d              = '0;
          pulse_d[PI_CLICK]   = 1'b1;
          pulse_d[PI_RELEASE] = 1'b1;
        end else if (hold_d >= LONG_V) begin
          state_d          = ST_LONG;
          pulse_d[PI_LONG] = 1'b1;
        end
      end
      ST_LONG: begin
        hold_d = hold_q;
        if (cnt_d < REL_V) begin
          state_d             = ST_IDLE;
          hold_d              = '0;
          pulse_d[PI_RELEASE] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_en) begin
      cnt_d   = '0;
      hold_d  = '0;
      state_d = ST_IDLE;
      pulse_d = '0;
    end
  end
  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      pulse_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end
  assign o_pressed = state_q != ST_IDLE;
  assign o_long    = state_q == ST_LONG;
  assign o_pulse   = pulse_q;
endmodule

// File: rtl/btn_filter_mc.sv
// btn_filter_mc: multi-channel push-button qualifier on the 32 kHz always-on clock.
module btn_filter_mc
  import btn_filter_pkg::*;
#(
  parameter int unsigned        NUM_CH     = 4,
  parameter int unsigned        CNT_W      = 14,
  parameter int unsigned        PRESS_TH   = 4096,
  parameter int unsigned        RELEASE_TH = 2048,
  parameter int unsigned        DEC_STEP   = 115,
  parameter int unsigned        HOLD_W     = 17,
  parameter int unsigned        LONG_TH    = 65536,
  parameter logic [NUM_CH-1:0]  ACT_LOW    = {NUM_CH{1'b1}}
) (
  input  logic              i_clk_32k,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_btn,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_pressed,
  output logic [NUM_CH-1:0] o_long,
  output logic [NUM_CH-1:0] o_press_pulse,
  output logic [NUM_CH-1:0] o_click_pulse,
  output logic [NUM_CH-1:0] o_long_pulse,
  output logic [NUM_CH-1:0] o_release_pulse
);
  if (!(RELEASE_TH <= PRESS_TH && PRESS_TH < (64'd1 << CNT_W))) begin : g_bad_th
    $error("btn_filter_mc: need RELEASE_TH <= PRESS_TH < 2**CNT_W");
  end
  if (!(LONG_TH < (64'd1 << HOLD_W))) begin : g_bad_long
    $error("btn_filter_mc: need LONG_TH < 2**HOLD_W");
  end
  if (DEC_STEP == 0) begin : g_bad_dec
    $error("btn_filter_mc: need DEC_STEP > 0");
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_PULSE-1:0] pulse;
    btn_filter_ch #(
      .CNT_W      (CNT_W),
      .PRESS_TH   (PRESS_TH),
      .RELEASE_TH (RELEASE_TH),
      .DEC_STEP   (DEC_STEP),
      .HOLD_W     (HOLD_W),
      .LONG_TH    (LONG_TH),
      .ACT_LOW    (ACT_LOW[c])
    ) u_ch (
      .i_clk_32k (i_clk_32k),
      .i_rst_n   (i_rst_n),
      .i_btn     (i_btn[c]),
      .i_en      (i_ch_en[c]),
      .o_pressed (o_pressed[c]),
      .o_long    (o_long[c]),
      .o_pulse   (pulse)
    );
    assign o_press_pulse[c]   = pulse[PI_PRESS];
    assign o_click_pulse[c]   = pulse[PI_CLICK];
    assign o_long_pulse[c]    = pulse[PI_LONG];
    assign o_release_pulse[c] = pulse[PI_RELEASE];
  end
endmodule

// File: tb/tb_btn_filter_mc.sv
// tb_btn_filter_mc: directed self-checking bench for btn_filter_mc with a small two-channel build.
module tb_btn_filter_mc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn, en;
  logic [1:0] pressed, lng, press_p, click_p, long_p, rel_p;
  int checks = 0;
  int errors = 0;
  btn_filter_mc #(
    .NUM_CH(2), .CNT_W(4), .PRESS_TH(8), .RELEASE_TH(4), .DEC_STEP(3),
    .HOLD_W(6), .LONG_TH(20), .ACT_LOW(2'b11)
  ) dut (
    .i_clk_32k       (clk),
    .i_rst_n         (rst_n),
    .i_btn           (btn),
    .i_ch_en         (en),
    .o_pressed       (pressed),
    .o_long          (lng),
    .o_press_pulse   (press_p),
    .o_click_pulse   (click_p),
    .o_long_pulse    (long_p),
    .o_release_pulse (rel_p)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    btn   = 2'b11;
    en    = 2'b11;
    tick(3);
    chk("rst_pressed", pressed, 2'b00);
    chk("rst_long", lng, 2'b00);
    chk("rst_press_p", press_p, 2'b00);
    chk("rst_click_p", click_p, 2'b00);
    chk("rst_long_p", long_p, 2'b00);
    chk("rst_rel_p", rel_p, 2'b00);
    rst_n = 1'b1;
    tick(2);
    // press qualification takes PRESS_TH+2 edges
    btn[0] = 1'b0;
    tick(9);
    chk("t1_pressed_e9", pressed, 2'b00);
    tick(1);
    chk("t1_pressed_e10", pressed, 2'b01);
    chk("t1_press_p_e10", press_p, 2'b01);
    chk("t1_click_p_e10", click_p, 2'b00);
    tick(1);
    chk("t1_press_p_e11", press_p, 2'b00);
    chk("t1_pressed_e11", pressed, 2'b01);
    // saturate at 15, then release: 12,9,6,3 -> click
    tick(7);
    btn[0] = 1'b1;
    tick(5);
    chk("t3_pressed_hold", pressed, 2'b01);
    chk("t3_rel_p_early", rel_p, 2'b00);
    tick(1);
    chk("t3_pressed_fall", pressed, 2'b00);
    chk("t3_click_p", click_p, 2'b01);
    chk("t3_rel_p", rel_p, 2'b01);
    chk("t3_long_p", long_p, 2'b00);
    tick(1);
    chk("t3_click_p_end", click_p, 2'b00);
    chk("t3_rel_p_end", rel_p, 2'b00);
    // short glitch: 5 cycles low never qualifies
    btn[0] = 1'b0;
    tick(5);
    btn[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t2_no_press_p", press_p, 2'b00);
      chk("t2_no_pressed", pressed, 2'b00);
    end
    // long press; integrator must have drained back to 0
    btn[0] = 1'b0;
    tick(9);
    chk("t4_pressed_e9", pressed, 2'b00);
    tick(1);
    chk("t4_press_p", press_p, 2'b01);
    tick(19);
    chk("t4_long_p_early", long_p, 2'b00);
    chk("t4_long_early", lng, 2'b00);
    tick(1);
    chk("t4_long_p", long_p, 2'b01);
    chk("t4_long", lng, 2'b01);
    chk("t4_pressed_long", pressed, 2'b01);
    tick(1);
    chk("t4_long_p_end", long_p, 2'b00);
    chk("t4_long_hold", lng, 2'b01);
    btn[0] = 1'b1;
    tick(5);
    chk("t4_long_still", lng, 2'b01);
    tick(1);
    chk("t4_rel_p", rel_p, 2'b01);
    chk("t4_no_click", click_p, 2'b00);
    chk("t4_pressed_off", pressed, 2'b00);
    chk("t4_long_off", lng, 2'b00);
    tick(3);
    // both channels together, then disable ch1
    btn = 2'b00;
    tick(10);
    chk("t5_press_p_both", press_p, 2'b11);
    chk("t5_pressed_both", pressed, 2'b11);
    tick(2);
    en[1] = 1'b0;
    tick(1);
    chk("t5_pressed_dis", pressed, 2'b01);
    chk("t5_rel_p_dis", rel_p, 2'b00);
    chk("t5_click_p_dis", click_p, 2'b00);
    tick(3);
    chk("t5_pressed_dis2", pressed, 2'b01);
    en[1] = 1'b1;
    tick(7);
    chk("t5_ch1_requal_e7", pressed, 2'b01);
    tick(1);
    chk("t5_ch1_press_p", press_p, 2'b10);
    chk("t5_pressed_re", pressed, 2'b11);
    tick(7);
    chk("t5_ch0_long", lng, 2'b01);
    // async reset mid long-press
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pressed", pressed, 2'b00);
    chk("t6_async_long", lng, 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    chk("t6_pressed_e9", pressed, 2'b00);
    tick(1);
    chk("t6_press_p_e10", press_p, 2'b11);
    chk("t6_pressed_e10", pressed, 2'b11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
